// File: rtl/operate_uart_tx.sv
// Queues encoder operation bytes in a small FIFO and serializes each one as a
// UART 8N1 frame toward the host. Idle/no-op bytes are filtered out at capture.
module operate_uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int BAUD_W   = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_d, busy_d;

  logic [7:0]          prev_q;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_d;

  logic valid, push, pop, full, wr_en, drop_d, baud_end;

  // A held byte is pushed once: only the cycle where data_in changes counts.
  assign valid    = (data_in[1:0] == 2'b10) && (|data_in[6:2]);
  assign push     = valid && (data_in != prev_q);
  assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign wr_en    = push && (!full || pop);
  assign drop_d   = push && full && !pop;
  assign baud_end = (baud_q == BAUD_W'(BAUD_DIV - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Back-to-back frames: reload straight into START with no idle bit.
          if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx/busy are derived from the next state so the registered line leads by no cycle.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    count_d = fifo_count;
    unique case ({wr_en, pop})
      2'b10:   count_d = fifo_count + 1'b1;
      2'b01:   count_d = fifo_count - 1'b1;
      default: count_d = fifo_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      drop       <= 1'b0;
      prev_q     <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      busy       <= busy_d;
      drop       <= drop_d;
      prev_q     <= data_in;
      fifo_count <= count_d;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {1'b0, data_in[6:0]};
  end

endmodule

// File: tb/tb_operate_uart_tx.sv
// Directed bench for operate_uart_tx at BAUD_DIV=10, FIFO_DEPTH=4: vector table
// for capture/FIFO behaviour plus cycle-exact frame checks against a line model.
module tb_operate_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       drop;

  int nchecks = 0;
  int nerrors = 0;

  operate_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [2:0] count;
    logic       drop;
    logic       busy;
    logic       tx;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] exp_bytes [8];
  int         n_frames;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected line level k cycles after the edge that pushed the first byte.
  function automatic logic exp_tx(input int k);
    int f, s;
    if (k < 1 || k > n_frames * 100) return 1'b1;
    f = (k - 1) / 100;
    s = ((k - 1) % 100) / 10;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return exp_bytes[f][s-1];
  endfunction

  task automatic check_line(input int k);
    check("tx", tx, exp_tx(k));
    check("busy", busy, (k >= 1 && k <= n_frames * 100));
  endtask

  initial begin
    int peak;

    // Invalid/idle patterns first, then a six-byte burst into an idle FIFO.
    vecs[0]  = '{8'h02, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'h7D, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h7F, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'h82, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h02, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h06, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h0A, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h12, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h22, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h42, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'h06, 3'd4, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{8'h02, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{8'h02, 3'd4, 1'b0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    data_in = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_drop", drop, 1'b0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 100; i++) tick();
    check("idle_tx", tx, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_count", fifo_count, 3'd0);

    for (int i = 0; i < 13; i++) begin
      data_in = vecs[i].din;
      tick();
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].count);
      check($sformatf("vec%0d_drop", i), drop, vecs[i].drop);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_tx", i), tx, vecs[i].tx);
    end

    // Continue the burst: frames back-to-back, plus a push on the first STOP-end pop while full.
    exp_bytes[0] = 8'h06; exp_bytes[1] = 8'h0A; exp_bytes[2] = 8'h12;
    exp_bytes[3] = 8'h22; exp_bytes[4] = 8'h42; exp_bytes[5] = 8'h12;
    n_frames = 6;
    for (int k = 8; k <= 601; k++) begin
      data_in = (k == 101) ? 8'h12 : 8'h02;
      tick();
      check_line(k);
      if (k == 101) begin
        check("full_pushpop_count", fifo_count, 3'd4);
        check("full_pushpop_drop", drop, 1'b0);
      end
    end
    check("burst_end_count", fifo_count, 3'd0);

    // Single GET byte, cycle-exact frame and busy fall at N+101.
    exp_bytes[0] = 8'h06;
    n_frames = 1;
    data_in = 8'h06;
    tick();
    check("get_count", fifo_count, 3'd1);
    check_line(0);
    data_in = 8'h02;
    for (int k = 1; k <= 101; k++) begin
      tick();
      check_line(k);
    end

    // Held byte with bit 7 set: one frame of 8'h06, queue depth never above 1.
    peak = 0;
    data_in = 8'h86;
    for (int k = 0; k <= 110; k++) begin
      if (k == 50) data_in = 8'h02;
      tick();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      check_line(k);
    end
    check("held_peak", peak, 1);

    // Asynchronous reset 35 cycles into a frame of 8'h0A (line low at that point).
    exp_bytes[0] = 8'h0A;
    data_in = 8'h0A;
    tick();
    data_in = 8'h02;
    for (int k = 1; k <= 35; k++) begin
      tick();
      check_line(k);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_count", fifo_count, 3'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      check("post_rst_tx", tx, 1'b1);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_count", fifo_count, 3'd0);
    end
    data_in = 8'h22;
    tick();
    check("new_byte_count", fifo_count, 3'd1);
    data_in = 8'h02;
    tick();
    check("new_byte_tx", tx, 1'b0);
    check("new_byte_busy", busy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
